// File: rtl/mem_wb_writeback_if.sv
// MEM-stage to writeback bundle: instruction control, result candidates and
// the stall/flush controls that steer the MEM/WB register.
interface mem_wb_writeback_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] ExResult;
  logic [XLEN-1:0] ReadData;
  logic [XLEN-1:0] PCPlus4;
  logic [XLEN-1:0] ImmExt;
  logic [1:0]      ResultSrc;
  logic            RegWrite;
  logic            WBDst;
  logic [AW-1:0]   Rd;

  modport master (
    output in_valid, stall, flush, ExResult, ReadData, PCPlus4, ImmExt,
           ResultSrc, RegWrite, WBDst, Rd
  );

  modport slave (
    input  in_valid, stall, flush, ExResult, ReadData, PCPlus4, ImmExt,
           ResultSrc, RegWrite, WBDst, Rd
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, writeback select, integer and FP register files.
// Optional macro RETIRE_COUNT_EN adds a 64-bit retired-instruction counter.
module mem_wb_writeback #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_wb_writeback_if.slave mem,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [AW-1:0]   fa1,
  input  logic [AW-1:0]   fa2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] fd1,
  output logic [XLEN-1:0] fd2,
  output logic            wb_valid,
  output logic            wb_is_fp,
  output logic [AW-1:0]   wb_rd,
`ifdef RETIRE_COUNT_EN
  output logic [63:0]     instret,
`endif
  output logic [XLEN-1:0] wb_data
);

  function automatic logic [XLEN-1:0] wb_sel(
    input logic [1:0]      src,
    input logic [XLEN-1:0] ex,
    input logic [XLEN-1:0] ld,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] imm
  );
    case (src)
      2'b00:   wb_sel = ex;
      2'b01:   wb_sel = ld;
      2'b10:   wb_sel = pc4;
      default: wb_sel = imm;
    endcase
  endfunction

  logic            vld_p1;
  logic            regwrite_p1;
  logic            wbdst_p1;
  logic [AW-1:0]   rd_p1;
  logic [1:0]      src_p1;
  logic [XLEN-1:0] ex_p1;
  logic [XLEN-1:0] ld_p1;
  logic [XLEN-1:0] pc4_p1;
  logic [XLEN-1:0] imm_p1;

  logic [XLEN-1:0] xreg [NREGS];
  logic [XLEN-1:0] freg [NREGS];

  logic we;
  logic x_we;
  logic f_we;

  // MEM -> WB register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      wbdst_p1    <= 1'b0;
      rd_p1       <= '0;
      src_p1      <= 2'b00;
      ex_p1       <= '0;
      ld_p1       <= '0;
      pc4_p1      <= '0;
      imm_p1      <= '0;
    end else if (mem.stall) begin
      vld_p1      <= vld_p1;
    end else if (mem.flush) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
    end else begin
      vld_p1      <= mem.in_valid;
      regwrite_p1 <= mem.RegWrite;
      wbdst_p1    <= mem.WBDst;
      rd_p1       <= mem.Rd;
      src_p1      <= mem.ResultSrc;
      ex_p1       <= mem.ExResult;
      ld_p1       <= mem.ReadData;
      pc4_p1      <= mem.PCPlus4;
      imm_p1      <= mem.ImmExt;
    end
  end

  assign wb_data  = wb_sel(src_p1, ex_p1, ld_p1, pc4_p1, imm_p1);
  assign we       = vld_p1 & regwrite_p1;
  assign x_we     = we & ~wbdst_p1 & (rd_p1 != '0);
  assign f_we     = we & wbdst_p1;
  assign wb_valid = x_we | f_we;
  assign wb_is_fp = wbdst_p1;
  assign wb_rd    = rd_p1;

  // WB -> register file commit boundary; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        xreg[i] <= '0;
        freg[i] <= '0;
      end
    end else begin
      if (x_we) xreg[rd_p1] <= wb_data;
      if (f_we) freg[rd_p1] <= wb_data;
    end
  end

  // Same-cycle write-through so decode never sees a stale operand
  assign rd1 = (ra1 == '0) ? '0 : (x_we && ra1 == rd_p1) ? wb_data : xreg[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (x_we && ra2 == rd_p1) ? wb_data : xreg[ra2];
  assign fd1 = (f_we && fa1 == rd_p1) ? wb_data : freg[fa1];
  assign fd2 = (f_we && fa2 == rd_p1) ? wb_data : freg[fa2];

`ifdef RETIRE_COUNT_EN
  logic [63:0] instret_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret_p1 <= 64'd0;
    else if (vld_p1 && !mem.stall)
      instret_p1 <= instret_p1 + 64'd1;
  end

  assign instret = instret_p1;
`endif

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- Downstream neighbour of the execute/memory stage: MEM/WB pipeline register, writeback result select, and the integer and floating-point register files.
- Captures the ALU/FPU result, the load data and control produced by execute/memory, then commits one result per instruction to x- or f-registers.
- Exposes write-through read ports to decode and a writeback bus to the forwarding unit.

Parameters:
- XLEN, 32, datapath width for results and registers.
- NREGS, 32, registers per file; index width = clog2(NREGS).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present in MEM stage
- stall  in  1  hold MEM/WB register contents
- flush  in  1  insert bubble into MEM/WB
- ExResult  in  XLEN  selected ALU/FPU result from MEM stage
- ReadData  in  XLEN  data-memory load output
- PCPlus4  in  XLEN  return address for jal/jalr
- ImmExt  in  XLEN  extended immediate (lui)
- ResultSrc  in  2  00 ExResult, 01 ReadData, 10 PCPlus4, 11 ImmExt
- RegWrite  in  1  instruction writes a register
- WBDst  in  1  0 integer file, 1 FP file
- Rd  in  5  destination index
- ra1, ra2  in  5 each  integer read addresses (decode)
- fa1, fa2  in  5 each  FP read addresses (decode)
- rd1, rd2  out  XLEN each  integer read data
- fd1, fd2  out  XLEN each  FP read data
- wb_valid  out  1  MEM/WB holds a valid writing instruction
- wb_is_fp  out  1  registered WBDst
- wb_rd  out  5  registered Rd
- wb_data  out  XLEN  selected writeback value

Behaviour:
- Reset (async, rst_n low): valid_q, RegWrite_q, WBDst_q, Rd_q, ResultSrc_q and all data registers cleared to 0; every register in both files cleared to 0. All outputs read 0 while reset is asserted.
- MEM/WB register update on each rising edge, in priority order:
  - stall=1: hold all fields. Stall wins over flush.
  - flush=1: valid_q<=0, RegWrite_q<=0; data fields don't-care.
  - otherwise: capture all inputs; valid_q<=in_valid.
- wb_data is combinational from the registered fields: mux(ResultSrc_q) over ExResult_q, ReadData_q, PCPlus4_q, ImmExt_q.
- Write enable we = valid_q & RegWrite_q.
  - WBDst_q=0 and Rd_q≠0: x[Rd_q]<=wb_data on the rising edge.
  - WBDst_q=1: f[Rd_q]<=wb_data. f0 is writable.
  - Rd_q=0 with WBDst_q=0: no write; x0 always reads 0.
- Writes repeat on every edge while the stage is stalled. This is idempotent, since the value is unchanged.
- Read ports are combinational with write-through: if we is active and the read address matches Rd_q in the same file (and is not x0), return wb_data instead of the array value. Read latency 0.
- wb_valid = we & ~(WBDst_q=0 & Rd_q=0). wb_rd and wb_is_fp mirror the registered fields.
- Latency: an instruction accepted at edge N is visible on wb_* during cycle N..N+1 and in the register file after edge N+1.
- Reset asserted mid-operation: pending writeback is discarded and the files are cleared.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- Defined: adds output instret [63:0], a retired-instruction counter.
  - Reset to 0.
  - Increments by 1 on each rising edge where valid_q=1 and stall=0, whether or not the instruction writes a register.
  - Wraps from 2^64-1 to 0.
- Undefined: no port and no counter logic.

Test Plan:
- Reset, then read ra1=5, fa1=5 -> rd1=0, fd1=0, wb_valid=0.
- ALU write: in_valid=1, RegWrite=1, WBDst=0, Rd=3, ResultSrc=00, ExResult=0x0000_1234 -> next cycle wb_data=0x1234, wb_valid=1; ra1=3 bypasses 0x1234 the same cycle; after the following edge, rd1=0x1234 with no active write.
- Load to FP: ResultSrc=01, ReadData=0x3F80_0000, WBDst=1, Rd=0 -> f0=0x3F80_0000. Integer write to Rd=0 with ExResult=0xDEAD_BEEF -> x0 reads 0 and wb_valid=0.
- Source select: ResultSrc=10 with PCPlus4=0x0000_0104 -> wb_data=0x104. ResultSrc=11 with ImmExt=0x0001_2000 -> wb_data=0x12000.
- Stall+flush: stall=1 and flush=1 together -> contents held, write repeated with the same value. flush=1 alone -> wb_valid=0 next cycle, no register changes.
- RETIRE_COUNT_EN: 10 valid instructions with 3 stall cycles interleaved -> instret=10. Assert rst_n=0 mid-stream -> instret=0 immediately.
